puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Sequencer for the 8-bit arbiter PUF array (64-bit challenge, shared start line `s`, 8 response bits).
- Accepts a challenge over a valid/ready request port and holds it stable on the PUF challenge lines.
- Fires the start edge NUM_EVAL times, samples the response after a settle window each time, and majority-votes every bit.
- Returns the stabilised 8-bit response over a valid/ready response port. Sits between the challenge source (UART/host FSM) and the PUF array.

Parameters:
- CW, 64, challenge width; drives all PUF challenge lines.
- RW, 8, response width; one bit per arbiter instance.
- PRE_CYC, 4, cycles `s` held low with the challenge stable before each rising edge (min 1).
- SETTLE_CYC, 16, cycles from the `s` rising edge to the response sample (min 2).
- NUM_EVAL, 5, evaluations per challenge; odd, 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  challenge request valid.
- req_ready  out  1  controller can accept a challenge.
- req_chal  in  CW  challenge value.
- puf_s  out  1  start signal to the PUF array (both arbiter inputs).
- puf_c  out  CW  challenge applied to the PUF array.
- puf_q  in  RW  raw arbiter responses.
- rsp_valid  out  1  voted response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  RW  majority-voted response.
- rsp_unstable  out  RW  per bit, 1 if any evaluation disagreed with the voted value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, puf_s=0, puf_c=0, rsp_valid=0, rsp_data=0, rsp_unstable=0, busy=0, req_ready=1, evaluation counter=0, per-bit ones counters=0.
- Reset asserted in any state returns to IDLE on the next edge. An in-flight challenge is discarded and no response is produced. puf_s drops to 0 on that edge.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch req_chal into puf_c, clear the evaluation counter and all ones counters, go to PRE. req_ready=0 from the next cycle.
  - PRE: puf_s=0, puf_c stable. Count PRE_CYC cycles, then go to FIRE. puf_s=1 is registered on the transition edge.
  - FIRE: puf_s=1. Count SETTLE_CYC cycles including the rising-edge cycle. On the last count cycle, capture puf_q, go to ACC.
  - ACC (1 cycle): ones_cnt[i] += captured bit i; increment the evaluation counter; puf_s <= 0. If the counter reaches NUM_EVAL go to VOTE, else go to PRE. Each re-evaluation always includes a full PRE_CYC low phase.
  - VOTE (1 cycle): rsp_data[i] = (ones_cnt[i] > NUM_EVAL/2). rsp_unstable[i] = (ones_cnt[i] != 0) && (ones_cnt[i] != NUM_EVAL). Set rsp_valid=1, go to RESP.
  - RESP: rsp_valid held, rsp_data/rsp_unstable stable. On rsp_valid&rsp_ready, rsp_valid <= 0 and go to IDLE.
- The next challenge can be accepted no earlier than the cycle after the RESP handshake. There is no overlap: req_ready is low in RESP.
- Arithmetic and widths:
  - Ones counters are ceil(log2(NUM_EVAL+1)) bits and cannot overflow.
  - The evaluation counter is the same width.
  - Timing counters are sized for max(PRE_CYC, SETTLE_CYC) and reload on each state entry.
- Latency from the request handshake to rsp_valid rising = NUM_EVAL*(PRE_CYC+SETTLE_CYC+1)+2 cycles. Default: 5*21+2 = 107.
- puf_c stays at the last challenge after completion; it is not cleared on return to IDLE, only on reset.
- The ones counter increments only in ACC, so puf_q changes outside the sample cycle have no effect.
- req_chal changes while busy are ignored.
- rsp_ready asserted outside RESP has no effect.
- puf_q is treated as asynchronous to clk. The capture uses a 2-flop synchroniser feeding the sample register, and SETTLE_CYC >= 2 absorbs the synchroniser delay.

Test Plan:
- Reset, then req_chal=64'hA5A5_0000_FFFF_1234 with req_valid=1 and puf_q modelled as constant 8'h3C → puf_c=64'hA5A5_0000_FFFF_1234 from the cycle after the handshake. puf_s pulses 5 times, each low 4 / high 17 cycles. rsp_valid rises 107 cycles after the handshake with rsp_data=8'h3C, rsp_unstable=8'h00.
- Bit-0 noise: puf_q[0] sampled as 1,0,1,0,1 across the 5 evaluations, other bits 0 → rsp_data=8'h01, rsp_unstable=8'h01. Sequence 0,0,1,0,1 → rsp_data=8'h00, rsp_unstable=8'h01.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_valid and rsp_data are held constant and req_ready stays 0. rsp_ready=1 → rsp_valid=0 and req_ready=1 on the next cycle.
- Second request: req_valid held 1 with a new challenge during busy → the new challenge is not accepted until after the RESP handshake, and puf_c changes only then.
- Mid-operation reset: assert rst during the 3rd FIRE phase → next cycle puf_s=0, puf_c=0, busy=0, req_ready=1, and rsp_valid is never asserted for that challenge.
- NUM_EVAL=1, PRE_CYC=1, SETTLE_CYC=2 build, puf_q=8'hFF → rsp_data=8'hFF, rsp_unstable=8'h00, latency 1*(1+2+1)+2 = 6 cycles.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: holds a challenge on the array, fires the
// start line NUM_EVAL times, majority-votes each response bit and returns the
// voted response together with a per-bit instability flag.

// Per-bit ones counter and majority vote for one arbiter instance.
module puf_eval_lane #(
  parameter int CNT_W    = 3,
  parameter int NUM_EVAL = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic acc,
  input  logic vote,
  input  logic smp,
  output logic vote_q,
  output logic unst_q
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_EVAL / 2);
  localparam logic [CNT_W-1:0] NE   = CNT_W'(NUM_EVAL);

  logic [CNT_W-1:0] ones;

  // Count ones across evaluations; resolve vote and disagreement in VOTE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones   <= '0;
      vote_q <= 1'b0;
      unst_q <= 1'b0;
    end else begin
      if (clr)      ones <= '0;
      else if (acc) ones <= ones + CNT_W'(smp);
      if (vote) begin
        vote_q <= (ones > HALF);
        unst_q <= (ones != '0) && (ones != NE);
      end
    end
  end
endmodule

module puf_eval_ctrl #(
  parameter int CW         = 64,
  parameter int RW         = 8,
  parameter int PRE_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int NUM_EVAL   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_chal,
  output logic          puf_s,
  output logic [CW-1:0] puf_c,
  input  logic [RW-1:0] puf_q,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic [RW-1:0] rsp_unstable,
  output logic          busy
);
  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam int MAXC  = (PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC;
  localparam int TW    = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] NE = CNT_W'(NUM_EVAL);

  typedef enum logic [2:0] {IDLE, PRE, FIRE, ACC, VOTE, RESP} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tmr;
  logic [CNT_W-1:0] eval_cnt;
  logic [CNT_W-1:0] eval_inc;
  logic [RW-1:0]    q_s1, q_s2, q_smp;
  logic             take;
  logic             last_fire;

  assign take      = (state == IDLE) && req_valid && req_ready;
  assign last_fire = (state == FIRE) && (tmr == '0);
  assign eval_inc  = eval_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)          state_nxt = PRE;
      PRE:     if (tmr == '0)     state_nxt = FIRE;
      FIRE:    if (tmr == '0)     state_nxt = ACC;
      ACC:     state_nxt = (eval_inc == NE) ? VOTE : PRE;
      VOTE:    state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer reloads on every state entry so each re-evaluation gets a full low phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        PRE:     tmr <= TW'(PRE_CYC - 1);
        FIRE:    tmr <= TW'(SETTLE_CYC - 1);
        default: tmr <= '0;
      endcase
    end else if (tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  // puf_q is asynchronous: two-flop synchroniser, then sample on the last settle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_s1  <= '0;
      q_s2  <= '0;
      q_smp <= '0;
    end else begin
      q_s1 <= puf_q;
      q_s2 <= q_s1;
      if (last_fire) q_smp <= q_s2;
    end
  end

  // Registered control outputs, challenge latch and evaluation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      puf_s     <= 1'b0;
      puf_c     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      eval_cnt  <= '0;
    end else begin
      puf_s     <= (state_nxt == FIRE) || (state_nxt == ACC);
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (take) begin
        puf_c    <= req_chal;
        eval_cnt <= '0;
      end else if (state == ACC) begin
        eval_cnt <= eval_inc;
      end
    end
  end

  // One voter per arbiter instance.
  for (genvar i = 0; i < RW; i++) begin : g_lane
    puf_eval_lane #(.CNT_W(CNT_W), .NUM_EVAL(NUM_EVAL)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (take),
      .acc    (state == ACC),
      .vote   (state == VOTE),
      .smp    (q_smp[i]),
      .vote_q (rsp_data[i]),
      .unst_q (rsp_unstable[i])
    );
  end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: default build plus a minimal
// NUM_EVAL=1 / PRE_CYC=1 / SETTLE_CYC=2 build.
module tb_puf_eval_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready;
  logic [63:0] req_chal = '0;
  logic        puf_s;
  logic [63:0] puf_c;
  logic [7:0]  puf_q = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [7:0]  rsp_data, rsp_unstable;
  logic        busy;

  logic        req_valid_b = 1'b0, req_ready_b;
  logic [63:0] req_chal_b = '0;
  logic        puf_s_b;
  logic [63:0] puf_c_b;
  logic [7:0]  puf_q_b = '0;
  logic        rsp_valid_b, rsp_ready_b = 1'b0;
  logic [7:0]  rsp_data_b, rsp_unstable_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_eval_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_chal(req_chal), .puf_s(puf_s), .puf_c(puf_c), .puf_q(puf_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_unstable(rsp_unstable), .busy(busy)
  );

  puf_eval_ctrl #(.NUM_EVAL(1), .PRE_CYC(1), .SETTLE_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_chal(req_chal_b), .puf_s(puf_s_b), .puf_c(puf_c_b), .puf_q(puf_q_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .rsp_unstable(rsp_unstable_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the handshake cycle (cycle 0). Applies qv[e] for
  // evaluation e, checks pulse shape, and returns at the first rsp_valid cycle.
  task automatic wait_rsp(input logic [4:0][7:0] qv, input logic [63:0] exp_c,
                          input logic nv, input logic [63:0] nc);
    int   cyc = 0, hi = 0, lo = 0, idx = 0, pulses = 0;
    logic prev_s = 1'b0;
    bit   done = 0;
    puf_q = qv[0];
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = nv;
        req_chal  = nc;
        chk("puf_c_latched", puf_c, exp_c);
        chk("busy_hi", busy, 1);
        chk("req_ready_lo", req_ready, 0);
      end
      if (puf_s && !prev_s) begin
        chk("pre_low_len", lo, 4);
        pulses++;
        hi = 1;
      end else if (puf_s) begin
        hi++;
      end else if (prev_s) begin
        chk("fire_high_len", hi, 17);
        lo = 1;
        idx++;
        if (idx < 5) puf_q = qv[idx];
      end else begin
        lo++;
      end
      prev_s = puf_s;
      if (rsp_valid) begin
        done = 1;
        chk("latency", cyc, 107);
        chk("pulse_count", pulses, 5);
        chk("puf_c_held", puf_c, exp_c);
      end
    end
    if (!done) chk("rsp_timeout", 0, 1);
  endtask

  // Hold rsp_ready low for bp cycles, then complete the handshake.
  task automatic finish_rsp(input int bp);
    logic [7:0] d = rsp_data;
    logic [7:0] u = rsp_unstable;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, d);
      chk("bp_unst", rsp_unstable, u);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    int cyc;
    int seen;
    int rises;
    logic prev_s;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_puf_s", puf_s, 0);
    chk("rst_puf_c", puf_c, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_unst", rsp_unstable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_b_req_ready", req_ready_b, 1);

    // Stable response, with backpressure.
    @(negedge clk);
    req_chal = 64'hA5A5_0000_FFFF_1234;
    req_valid = 1'b1;
    chk("t1_req_ready", req_ready, 1);
    wait_rsp({5{8'h3C}}, 64'hA5A5_0000_FFFF_1234, 1'b0, '0);
    chk("t1_data", rsp_data, 8'h3C);
    chk("t1_unst", rsp_unstable, 8'h00);
    finish_rsp(20);

    // Bit-0 noise 1,0,1,0,1 -> voted 1, unstable.
    @(negedge clk);
    req_chal = 64'h1111;
    req_valid = 1'b1;
    chk("t2_req_ready", req_ready, 1);
    wait_rsp({8'h01, 8'h00, 8'h01, 8'h00, 8'h01}, 64'h1111, 1'b0, '0);
    chk("t2_data", rsp_data, 8'h01);
    chk("t2_unst", rsp_unstable, 8'h01);
    finish_rsp(0);

    // Bit-0 noise 0,0,1,0,1 -> voted 0, unstable; a second request is held
    // pending the whole time.
    @(negedge clk);
    req_chal = 64'h2222;
    req_valid = 1'b1;
    wait_rsp({8'h01, 8'h00, 8'h01, 8'h00, 8'h00}, 64'h2222, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    chk("t3_data", rsp_data, 8'h00);
    chk("t3_unst", rsp_unstable, 8'h01);
    finish_rsp(0);
    chk("t4_puf_c_old", puf_c, 64'h2222);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_puf_c_new", puf_c, 64'hDEAD_BEEF_0BAD_F00D);
    chk("t4_busy", busy, 1);

    // Reset in the third FIRE phase.
    rises = 0;
    prev_s = puf_s;
    cyc = 0;
    while (rises < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (puf_s && !prev_s) rises++;
      prev_s = puf_s;
    end
    chk("t5_reach_fire3", rises, 3);
    repeat (3) @(negedge clk);
    chk("t5_in_fire", puf_s, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_puf_s", puf_s, 0);
    chk("t5_puf_c", puf_c, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t5_no_rsp", seen, 0);

    // Minimal build: single evaluation, latency 6.
    @(negedge clk);
    req_chal_b = 64'h1;
    puf_q_b = 8'hFF;
    req_valid_b = 1'b1;
    chk("b_req_ready", req_ready_b, 1);
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      req_valid_b = 1'b0;
      if (rsp_valid_b) break;
    end
    chk("b_latency", cyc, 6);
    chk("b_data", rsp_data_b, 8'hFF);
    chk("b_unst", rsp_unstable_b, 8'h00);
    rsp_ready_b = 1'b1;
    @(negedge clk);
    rsp_ready_b = 1'b0;
    chk("b_rsp_drop", rsp_valid_b, 0);
    chk("b_req_ready_back", req_ready_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
